// File: rtl/flappy_game_ctrl.sv
// Flappy game-state controller: IDLE/PLAY/DYING/OVER sequencing, flap strobes, score and high score.
// All outputs registered (1 cycle after the sampled input); collisions take effect only at frame_tick.
module flappy_game_ctrl #(
  parameter int DIE_FRAMES   = 60,
  parameter int FLASH_FRAMES = 8,
  parameter int SCORE_W      = 8
) (
  input  logic               clock,
  input  logic               resetn,
  input  logic               did_collide,
  input  logic               frame_tick,
  input  logic               flap_btn,
  input  logic               col_passed,
  output logic               run,
  output logic               flap_pulse,
  output logic               flash,
  output logic               game_over,
  output logic [1:0]         state,
  output logic [SCORE_W-1:0] score,
  output logic [SCORE_W-1:0] high_score
);

  localparam int FL_BIT = $clog2(FLASH_FRAMES);
  localparam int DIE_W  = (DIE_FRAMES > 1) ? $clog2(DIE_FRAMES) : 1;
  localparam int CNT_W  = (DIE_W > FL_BIT + 1) ? DIE_W : FL_BIT + 1;
  localparam logic [CNT_W-1:0]   CNT_LAST  = CNT_W'(DIE_FRAMES - 1);
  localparam logic [SCORE_W-1:0] SCORE_MAX = '1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_PLAY  = 2'b01,
    S_DYING = 2'b10,
    S_OVER  = 2'b11
  } state_t;

  state_t             state_q, state_d;
  logic               btn_q;
  logic               hit_q, hit_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic [SCORE_W-1:0] high_q, high_d;
  logic               flap_q, flap_d;
  logic               flash_q, flash_d;
  logic               run_q, run_d;
  logic               over_q, over_d;
  logic               btn_edge;

  assign btn_edge = flap_btn & ~btn_q;

  always_comb begin
    state_d = state_q;
    hit_d   = hit_q;
    cnt_d   = cnt_q;
    score_d = score_q;
    high_d  = high_q;
    flap_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (btn_edge) begin
          state_d = S_PLAY;
          score_d = '0;
          hit_d   = 1'b0;
        end
      end
      S_PLAY: begin
        flap_d = btn_edge;
        if (col_passed && (score_q != SCORE_MAX)) begin
          score_d = score_q + SCORE_W'(1);
        end
        // Hits are remembered for the whole frame and judged only at its boundary.
        if (frame_tick) begin
          hit_d = 1'b0;
          if (hit_q | did_collide) begin
            state_d = S_DYING;
            cnt_d   = '0;
          end
        end else begin
          hit_d = hit_q | did_collide;
        end
      end
      S_DYING: begin
        if (frame_tick) begin
          if (cnt_q == CNT_LAST) begin
            state_d = S_OVER;
            if (score_q > high_q) begin
              high_d = score_q;
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      S_OVER: begin
        if (btn_edge) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    flash_d = (state_d == S_DYING) & cnt_d[FL_BIT];
    run_d   = (state_d == S_PLAY);
    over_d  = (state_d == S_OVER);
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      btn_q   <= 1'b1;
      hit_q   <= 1'b0;
      cnt_q   <= '0;
      score_q <= '0;
      high_q  <= '0;
      flap_q  <= 1'b0;
      flash_q <= 1'b0;
      run_q   <= 1'b0;
      over_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      btn_q   <= flap_btn;
      hit_q   <= hit_d;
      cnt_q   <= cnt_d;
      score_q <= score_d;
      high_q  <= high_d;
      flap_q  <= flap_d;
      flash_q <= flash_d;
      run_q   <= run_d;
      over_q  <= over_d;
    end
  end

  assign state      = state_q;
  assign run        = run_q;
  assign flap_pulse = flap_q;
  assign flash      = flash_q;
  assign game_over  = over_q;
  assign score      = score_q;
  assign high_score = high_q;

endmodule

// File: tb/tb_flappy_game_ctrl.sv
// Vector-table bench for flappy_game_ctrl with DIE_FRAMES=4, FLASH_FRAMES=2.
module tb_flappy_game_ctrl;

  logic       clk = 1'b0;
  logic       resetn, did_collide, frame_tick, flap_btn, col_passed;
  logic       run, flap_pulse, flash, game_over;
  logic [1:0] state;
  logic [7:0] score, high_score;

  always #5 clk = ~clk;

  flappy_game_ctrl #(.DIE_FRAMES(4), .FLASH_FRAMES(2), .SCORE_W(8)) dut (
    .clock(clk), .resetn(resetn), .did_collide(did_collide), .frame_tick(frame_tick),
    .flap_btn(flap_btn), .col_passed(col_passed), .run(run), .flap_pulse(flap_pulse),
    .flash(flash), .game_over(game_over), .state(state), .score(score), .high_score(high_score)
  );

  typedef struct {
    logic       rstn, btn, col, tick, cp;
    logic [1:0] st;
    logic       fp, fl;
    logic [7:0] sc, hi;
  } vec_t;

  typedef struct packed {
    logic [1:0] st;
    logic       run, fp, fl, go;
    logic [7:0] sc, hi;
  } exp_t;

  vec_t tbl[$];
  exp_t sb_q[$];
  int   n_vec = 0;
  int   n_bad = 0;

  task automatic add(input bit rstn, btn, col, tick, cp, input bit [1:0] st,
                     input bit fp, fl, input int sc, hi);
    vec_t v;
    v.rstn = rstn; v.btn = btn; v.col = col; v.tick = tick; v.cp = cp;
    v.st = st; v.fp = fp; v.fl = fl; v.sc = 8'(sc); v.hi = 8'(hi);
    tbl.push_back(v);
  endtask

  task automatic apply(input int idx, input vec_t v);
    exp_t e, a;
    resetn = v.rstn; flap_btn = v.btn; did_collide = v.col;
    frame_tick = v.tick; col_passed = v.cp;
    e.st = v.st; e.run = (v.st == 2'b01); e.fp = v.fp; e.fl = v.fl;
    e.go = (v.st == 2'b11); e.sc = v.sc; e.hi = v.hi;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    a = '{state, run, flap_pulse, flash, game_over, score, high_score};
    n_vec++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL vec%0d: got st=%b run=%b fp=%b fl=%b go=%b sc=%0d hi=%0d, want st=%b run=%b fp=%b fl=%b go=%b sc=%0d hi=%0d",
               idx, a.st, a.run, a.fp, a.fl, a.go, a.sc, a.hi,
               e.st, e.run, e.fp, e.fl, e.go, e.sc, e.hi);
    end
  endtask

  initial begin
    resetn = 1'b0; flap_btn = 1'b1; did_collide = 1'b0; frame_tick = 1'b0; col_passed = 1'b0;

    //  rstn btn col tick cp  st    fp fl sc hi
    add(0, 1, 0, 0, 0, 2'b00, 0, 0, 0, 0);   // reset with button held
    add(1, 1, 0, 0, 0, 2'b00, 0, 0, 0, 0);
    add(1, 1, 0, 0, 0, 2'b00, 0, 0, 0, 0);
    add(1, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0);
    add(1, 1, 0, 0, 0, 2'b01, 0, 0, 0, 0);   // start edge: no flap
    add(1, 1, 0, 0, 0, 2'b01, 0, 0, 0, 0);
    add(1, 0, 0, 0, 1, 2'b01, 0, 0, 1, 0);
    add(1, 0, 0, 0, 1, 2'b01, 0, 0, 2, 0);
    add(1, 0, 0, 0, 0, 2'b01, 0, 0, 2, 0);
    add(1, 0, 0, 0, 1, 2'b01, 0, 0, 3, 0);
    add(1, 1, 0, 0, 0, 2'b01, 1, 0, 3, 0);   // flap 1
    add(1, 1, 0, 0, 0, 2'b01, 0, 0, 3, 0);
    add(1, 0, 0, 0, 0, 2'b01, 0, 0, 3, 0);
    add(1, 1, 0, 0, 0, 2'b01, 1, 0, 3, 0);   // flap 2
    add(1, 0, 0, 0, 0, 2'b01, 0, 0, 3, 0);
    add(1, 0, 1, 0, 0, 2'b01, 0, 0, 3, 0);   // mid-frame hit
    add(1, 0, 0, 0, 0, 2'b01, 0, 0, 3, 0);
    add(1, 1, 0, 1, 0, 2'b10, 1, 0, 3, 0);   // tick -> DYING, flap with it
    add(1, 0, 0, 0, 0, 2'b10, 0, 0, 3, 0);
    add(1, 0, 0, 1, 0, 2'b10, 0, 0, 3, 0);
    add(1, 1, 0, 0, 0, 2'b10, 0, 0, 3, 0);   // flap ignored while dying
    add(1, 0, 0, 1, 0, 2'b10, 0, 1, 3, 0);
    add(1, 0, 0, 0, 0, 2'b10, 0, 1, 3, 0);
    add(1, 0, 0, 1, 0, 2'b10, 0, 1, 3, 0);
    add(1, 0, 1, 0, 1, 2'b10, 0, 1, 3, 0);
    add(1, 0, 0, 1, 0, 2'b11, 0, 0, 3, 3);   // 4th tick -> OVER
    add(1, 0, 0, 0, 0, 2'b11, 0, 0, 3, 3);
    add(1, 0, 1, 1, 1, 2'b11, 0, 0, 3, 3);
    add(1, 1, 0, 0, 0, 2'b00, 0, 0, 3, 3);
    add(1, 0, 0, 0, 0, 2'b00, 0, 0, 3, 3);
    add(1, 1, 0, 0, 0, 2'b01, 0, 0, 0, 3);   // game 2
    add(1, 0, 0, 0, 0, 2'b01, 0, 0, 0, 3);
    add(1, 0, 0, 1, 0, 2'b01, 0, 0, 0, 3);
    add(1, 0, 1, 1, 1, 2'b10, 0, 0, 1, 3);   // col_passed on collision tick counts
    add(1, 0, 0, 1, 0, 2'b10, 0, 0, 1, 3);
    add(1, 0, 0, 1, 0, 2'b10, 0, 1, 1, 3);
    add(1, 0, 0, 1, 0, 2'b10, 0, 1, 1, 3);
    add(1, 0, 0, 1, 0, 2'b11, 0, 0, 1, 3);
    add(1, 1, 0, 0, 0, 2'b00, 0, 0, 1, 3);
    add(1, 0, 0, 0, 0, 2'b00, 0, 0, 1, 3);
    add(1, 1, 0, 0, 0, 2'b01, 0, 0, 0, 3);   // game 3: saturate
    for (int i = 0; i < 260; i++)
      add(1, 0, 0, 0, 1, 2'b01, 0, 0, (i + 1 > 255) ? 255 : i + 1, 3);
    add(1, 0, 1, 1, 1, 2'b10, 0, 0, 255, 3);
    add(1, 0, 0, 1, 0, 2'b10, 0, 0, 255, 3);
    add(1, 0, 0, 1, 0, 2'b10, 0, 1, 255, 3);
    add(1, 0, 0, 1, 0, 2'b10, 0, 1, 255, 3);
    add(1, 0, 0, 1, 0, 2'b11, 0, 0, 255, 255);
    add(1, 1, 0, 0, 0, 2'b00, 0, 0, 255, 255);
    add(1, 0, 0, 0, 0, 2'b00, 0, 0, 255, 255);
    add(1, 1, 0, 0, 0, 2'b01, 0, 0, 0, 255);  // game 4: reset while dying
    add(1, 0, 1, 0, 0, 2'b01, 0, 0, 0, 255);
    add(1, 0, 0, 1, 0, 2'b10, 0, 0, 0, 255);
    add(1, 0, 0, 1, 0, 2'b10, 0, 0, 0, 255);
    add(0, 1, 0, 0, 0, 2'b00, 0, 0, 0, 0);
    add(1, 1, 0, 0, 0, 2'b00, 0, 0, 0, 0);
    add(1, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0);
    add(1, 1, 0, 0, 0, 2'b01, 0, 0, 0, 0);

    @(negedge clk);
    for (int i = 0; i < tbl.size(); i++) apply(i, tbl[i]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
